ahb3lite_interconnect_slave_port: RTL and testbench

- Slave-side port of the AHB3-Lite multi-layer interconnect; one instance per AHB slave.
- Collects access requests from every master port, arbitrates by 3-bit priority, grants one master, and muxes that master's address/control onto the slave's AHB bus.
- Routes HWDATA from the data-phase owner and broadcasts the slave's HRDATA/HREADY/HRESP back to all master ports.

---
 rtl/ahb3lite_interconnect_slave_port.sv | 175 +++++++++++++++++
 tb/tb_ahb3lite_interconnect_slave_port.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_interconnect_slave_port.sv
// ahb3lite_interconnect_slave_port
//
// Slave-side port of the AHB3-Lite multi-layer interconnect (one per AHB slave).
// Collects requests from all master ports and arbitrates on a 3-bit priority
// (higher wins). It grants one master, muxes that master's address/control onto
// the slave bus, and steers HWDATA from the data-phase owner. The slave's
// HRDATA/HREADY/HRESP are broadcast back to every master port.
//
// Optional feature: define AHB3LITE_SLAVE_PORT_RR_EN to break priority ties
// round-robin. Equal-priority requesters are then taken starting after the
// last granted index. With the macro undefined, the lowest index wins a tie.
//
// Ports:
//   HCLK, HRESETn       clock (rising edge), asynchronous active-low reset
//   mst*                per-master request / address-phase / write-data inputs
//   can_switch          per-master permission to re-arbitrate at the next edge
//   master_granted      one-hot current grant
//   mstHRDATA/HREADYOUT/HRESP  slave response broadcast to all masters
//   slv_*               AHB bus towards the slave

module ahb3lite_interconnect_slave_port #(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32,
  parameter int unsigned MASTERS    = 3
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,

  input  logic [2:0]            mstpriority  [MASTERS],
  input  logic [MASTERS-1:0]    mstHSEL,
  input  logic [HADDR_SIZE-1:0] mstHADDR     [MASTERS],
  input  logic [HDATA_SIZE-1:0] mstHWDATA    [MASTERS],
  input  logic [MASTERS-1:0]    mstHWRITE,
  input  logic [2:0]            mstHSIZE     [MASTERS],
  input  logic [2:0]            mstHBURST    [MASTERS],
  input  logic [3:0]            mstHPROT     [MASTERS],
  input  logic [1:0]            mstHTRANS    [MASTERS],
  input  logic [MASTERS-1:0]    mstHMASTLOCK,
  input  logic [MASTERS-1:0]    mstHREADY,
  input  logic [MASTERS-1:0]    can_switch,

  output logic [MASTERS-1:0]    master_granted,
  output logic [HDATA_SIZE-1:0] mstHRDATA,
  output logic                  mstHREADYOUT,
  output logic                  mstHRESP,

  output logic                  slv_HSEL,
  output logic [HADDR_SIZE-1:0] slv_HADDR,
  output logic [HDATA_SIZE-1:0] slv_HWDATA,
  input  logic [HDATA_SIZE-1:0] slv_HRDATA,
  output logic                  slv_HWRITE,
  output logic [2:0]            slv_HSIZE,
  output logic [2:0]            slv_HBURST,
  output logic [3:0]            slv_HPROT,
  output logic [1:0]            slv_HTRANS,
  output logic                  slv_HMASTLOCK,
  output logic                  slv_HREADYOUT,
  input  logic                  slv_HREADY,
  input  logic                  slv_HRESP
);

  localparam int unsigned     IW        = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int              NM        = int'(MASTERS);
  localparam logic [1:0]      HtransIdle = 2'b00;
  localparam logic [MASTERS-1:0] GntRst = MASTERS'(1);

  logic [MASTERS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      dp_q;
  logic [IW-1:0]      win_idx;
  logic               any_req;
  logic [2:0]         top_pri;
  logic               found;

`ifdef AHB3LITE_SLAVE_PORT_RR_EN
  logic [IW-1:0]      last_q;
  int unsigned        cand;
  logic [IW-1:0]      cand_idx;
`endif

  // Encode the one-hot grant into an index for the muxes.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt_q[i]) gnt_idx = IW'(i);
    end
  end

  // Highest priority among current requesters.
  always_comb begin
    any_req = 1'b0;
    top_pri = '0;
    for (int i = 0; i < NM; i++) begin
      if (mstHSEL[i] && (!any_req || (mstpriority[i] > top_pri))) begin
        any_req = 1'b1;
        top_pri = mstpriority[i];
      end
    end
  end

  // Pick a winner among the top-priority requesters; park on the current
  // grant when nobody requests.
  always_comb begin
    win_idx = gnt_idx;
    found   = 1'b0;
`ifdef AHB3LITE_SLAVE_PORT_RR_EN
    cand     = 0;
    cand_idx = '0;
    // Scan starting one past last_q; last_q itself is visited last.
    for (int k = 1; k <= NM; k++) begin
      cand     = (int'(last_q) + k) % NM;
      cand_idx = IW'(cand);
      if (!found && mstHSEL[cand_idx] && (mstpriority[cand_idx] == top_pri)) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
`else
    for (int i = 0; i < NM; i++) begin
      if (!found && mstHSEL[i] && (mstpriority[i] == top_pri)) begin
        found   = 1'b1;
        win_idx = IW'(i);
      end
    end
`endif
  end

  always_comb begin
    gnt_d          = '0;
    gnt_d[win_idx] = 1'b1;
  end

  // Grant moves only when the current owner allows it and the bus is ready.
  // Locked and undefined-length bursts are protected by can_switch alone.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt_q <= GntRst;
      dp_q  <= '0;
    end else if (slv_HREADY) begin
      dp_q <= gnt_idx;
      if (can_switch[gnt_idx]) gnt_q <= gnt_d;
    end
  end

`ifdef AHB3LITE_SLAVE_PORT_RR_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_q <= '0;
    end else if (slv_HREADY && can_switch[gnt_idx] && (win_idx != gnt_idx)) begin
      last_q <= win_idx;
    end
  end
`endif

  // Address phase follows the grant.
  assign master_granted = gnt_q;
  assign slv_HSEL       = mstHSEL[gnt_idx];
  assign slv_HADDR      = mstHADDR[gnt_idx];
  assign slv_HWRITE     = mstHWRITE[gnt_idx];
  assign slv_HSIZE      = mstHSIZE[gnt_idx];
  assign slv_HBURST     = mstHBURST[gnt_idx];
  assign slv_HPROT      = mstHPROT[gnt_idx];
  assign slv_HTRANS     = mstHSEL[gnt_idx] ? mstHTRANS[gnt_idx] : HtransIdle;
  assign slv_HMASTLOCK  = mstHMASTLOCK[gnt_idx];
  assign slv_HREADYOUT  = mstHREADY[gnt_idx];

  // Write data comes from the previous address-phase owner, which may no
  // longer hold the grant.
  assign slv_HWDATA     = mstHWDATA[dp_q];

  assign mstHRDATA      = slv_HRDATA;
  assign mstHREADYOUT   = slv_HREADY;
  assign mstHRESP       = slv_HRESP;

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_port.sv
// tb_ahb3lite_interconnect_slave_port
//
// Self-checking bench for ahb3lite_interconnect_slave_port (MASTERS = 3).
// A behavioural model tracks the granted master, the data-phase owner and the
// last grant. It computes the arbitration winner directly from the priority
// and tie-break rules. One compare process checks every DUT output against
// the model on each falling edge. Directed scenarios add literal expectations.
// A randomized phase follows them.

module tb_ahb3lite_interconnect_slave_port;

  localparam int M  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic [2:0]    mstpriority  [M];
  logic [M-1:0]  mstHSEL;
  logic [AW-1:0] mstHADDR     [M];
  logic [DW-1:0] mstHWDATA    [M];
  logic [M-1:0]  mstHWRITE;
  logic [2:0]    mstHSIZE     [M];
  logic [2:0]    mstHBURST    [M];
  logic [3:0]    mstHPROT     [M];
  logic [1:0]    mstHTRANS    [M];
  logic [M-1:0]  mstHMASTLOCK;
  logic [M-1:0]  mstHREADY;
  logic [M-1:0]  can_switch;
  logic [M-1:0]  master_granted;
  logic [DW-1:0] mstHRDATA;
  logic          mstHREADYOUT;
  logic          mstHRESP;
  logic          slv_HSEL;
  logic [AW-1:0] slv_HADDR;
  logic [DW-1:0] slv_HWDATA;
  logic [DW-1:0] slv_HRDATA;
  logic          slv_HWRITE;
  logic [2:0]    slv_HSIZE;
  logic [2:0]    slv_HBURST;
  logic [3:0]    slv_HPROT;
  logic [1:0]    slv_HTRANS;
  logic          slv_HMASTLOCK;
  logic          slv_HREADYOUT;
  logic          slv_HREADY;
  logic          slv_HRESP;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: plain integers, not the DUT's encoding.
  int m_gnt  = 0;
  int m_dp   = 0;
  int m_last = 0;

  int exp_rr [4];

  ahb3lite_interconnect_slave_port #(
    .HADDR_SIZE (AW),
    .HDATA_SIZE (DW),
    .MASTERS    (M)
  ) dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .mstpriority    (mstpriority),
    .mstHSEL        (mstHSEL),
    .mstHADDR       (mstHADDR),
    .mstHWDATA      (mstHWDATA),
    .mstHWRITE      (mstHWRITE),
    .mstHSIZE       (mstHSIZE),
    .mstHBURST      (mstHBURST),
    .mstHPROT       (mstHPROT),
    .mstHTRANS      (mstHTRANS),
    .mstHMASTLOCK   (mstHMASTLOCK),
    .mstHREADY      (mstHREADY),
    .can_switch     (can_switch),
    .master_granted (master_granted),
    .mstHRDATA      (mstHRDATA),
    .mstHREADYOUT   (mstHREADYOUT),
    .mstHRESP       (mstHRESP),
    .slv_HSEL       (slv_HSEL),
    .slv_HADDR      (slv_HADDR),
    .slv_HWDATA     (slv_HWDATA),
    .slv_HRDATA     (slv_HRDATA),
    .slv_HWRITE     (slv_HWRITE),
    .slv_HSIZE      (slv_HSIZE),
    .slv_HBURST     (slv_HBURST),
    .slv_HPROT      (slv_HPROT),
    .slv_HTRANS     (slv_HTRANS),
    .slv_HMASTLOCK  (slv_HMASTLOCK),
    .slv_HREADYOUT  (slv_HREADYOUT),
    .slv_HREADY     (slv_HREADY),
    .slv_HRESP      (slv_HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Winner from the rules: highest priority among requesters; ties go to the
  // lowest index, or (round-robin) to the smallest forward distance past the
  // last grant; no requests parks on the current grant.
  function automatic int model_winner();
    int best;
    int win;
    int bd;
    int d;
    best = -1;
    win  = m_gnt;
    for (int i = 0; i < M; i++)
      if (mstHSEL[i] && int'(mstpriority[i]) > best) best = int'(mstpriority[i]);
    if (best < 0) return m_gnt;
`ifdef AHB3LITE_SLAVE_PORT_RR_EN
    bd = M + 1;
    for (int i = 0; i < M; i++) begin
      if (mstHSEL[i] && int'(mstpriority[i]) == best) begin
        d = (i - m_last + M) % M;
        if (d == 0) d = M;
        if (d < bd) begin
          bd  = d;
          win = i;
        end
      end
    end
`else
    bd = 0;
    d  = 0;
    for (int i = M - 1; i >= 0; i--)
      if (mstHSEL[i] && int'(mstpriority[i]) == best) win = i;
`endif
    return win;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_gnt  <= 0;
      m_dp   <= 0;
      m_last <= 0;
    end else if (slv_HREADY) begin
      m_dp <= m_gnt;
      if (can_switch[m_gnt]) begin
        m_gnt <= model_winner();
        if (model_winner() != m_gnt) m_last <= model_winner();
      end
    end
  end

  // Single compare process: every output, every cycle.
  always @(negedge HCLK) begin
    chk("master_granted", 64'(master_granted), 64'(1) << m_gnt);
    chk("slv_HSEL",       64'(slv_HSEL),       64'(mstHSEL[m_gnt]));
    chk("slv_HADDR",      64'(slv_HADDR),      64'(mstHADDR[m_gnt]));
    chk("slv_HWRITE",     64'(slv_HWRITE),     64'(mstHWRITE[m_gnt]));
    chk("slv_HSIZE",      64'(slv_HSIZE),      64'(mstHSIZE[m_gnt]));
    chk("slv_HBURST",     64'(slv_HBURST),     64'(mstHBURST[m_gnt]));
    chk("slv_HPROT",      64'(slv_HPROT),      64'(mstHPROT[m_gnt]));
    chk("slv_HTRANS",     64'(slv_HTRANS),
        mstHSEL[m_gnt] ? 64'(mstHTRANS[m_gnt]) : 64'(0));
    chk("slv_HMASTLOCK",  64'(slv_HMASTLOCK),  64'(mstHMASTLOCK[m_gnt]));
    chk("slv_HREADYOUT",  64'(slv_HREADYOUT),  64'(mstHREADY[m_gnt]));
    chk("slv_HWDATA",     64'(slv_HWDATA),     64'(mstHWDATA[m_dp]));
    chk("mstHRDATA",      64'(mstHRDATA),      64'(slv_HRDATA));
    chk("mstHREADYOUT",   64'(mstHREADYOUT),   64'(slv_HREADY));
    chk("mstHRESP",       64'(mstHRESP),       64'(slv_HRESP));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic defaults();
    for (int i = 0; i < M; i++) begin
      mstpriority[i] = 3'd0;
      mstHADDR[i]    = 32'h1000 * (i + 1);
      mstHWDATA[i]   = 32'hA000_0000 + i;
      mstHSIZE[i]    = 3'd2;
      mstHBURST[i]   = 3'd0;
      mstHPROT[i]    = 4'h3;
      mstHTRANS[i]   = 2'b10;
    end
    mstHSEL      = '0;
    mstHWRITE    = '0;
    mstHMASTLOCK = '0;
    mstHREADY    = '1;
    can_switch   = '1;
    slv_HRDATA   = 32'h5555_AAAA;
    slv_HREADY   = 1'b1;
    slv_HRESP    = 1'b0;
  endtask

  initial begin
`ifdef AHB3LITE_SLAVE_PORT_RR_EN
    exp_rr = '{1, 2, 0, 1};
`else
    exp_rr = '{0, 0, 0, 0};
`endif
    defaults();
    tick(2);
    chk("reset_grant", 64'(master_granted), 64'h1);
    chk("reset_hsel",  64'(slv_HSEL), 64'h0);
    chk("reset_htrans_idle", 64'(slv_HTRANS), 64'h0);
    HRESETn = 1'b1;

    // Master 1 requests NONSEQ SINGLE at 0x100, priority 0.
    mstHSEL        = 3'b010;
    mstHADDR[1]    = 32'h100;
    mstHTRANS[1]   = 2'b10;
    mstpriority[1] = 3'd0;
    #1 chk("t1_pre_grant", 64'(master_granted), 64'h1);
    tick(1);
    chk("t1_grant",  64'(master_granted), 64'h2);
    chk("t1_haddr",  64'(slv_HADDR), 64'h100);
    chk("t1_hsel",   64'(slv_HSEL), 64'h1);
    chk("t1_htrans", 64'(slv_HTRANS), 64'h2);

    // Masters 0 (pri 2) and 2 (pri 5) together.
    mstHSEL = 3'b101;
    mstpriority[0] = 3'd2;
    mstpriority[2] = 3'd5;
    tick(1);
    chk("t2_grant_m2", 64'(master_granted), 64'h4);
    tick(1);
    chk("t2_hold_m2", 64'(master_granted), 64'h4);
    mstHSEL = 3'b001;
    tick(1);
    chk("t2_grant_m0", 64'(master_granted), 64'h1);

    // Master 0 INCR4 blocks the switch while pri-7 master 1 waits.
    mstHSEL        = 3'b011;
    mstHBURST[0]   = 3'd3;
    can_switch[0]  = 1'b0;
    mstpriority[1] = 3'd7;
    for (int b = 0; b < 3; b++) begin
      tick(1);
      chk("t3_locked_m0", 64'(master_granted), 64'h1);
    end
    can_switch[0] = 1'b1;
    #1 chk("t3_pre_switch", 64'(master_granted), 64'h1);
    tick(1);
    chk("t3_grant_m1", 64'(master_granted), 64'h2);

    // Write data follows the address-phase owner across a grant change.
    mstHSEL = 3'b001;
    tick(1);
    chk("t4_grant_m0", 64'(master_granted), 64'h1);
    mstHWRITE[0]   = 1'b1;
    mstHWDATA[0]   = 32'hDEAD_BEEF;
    mstHWDATA[1]   = 32'h1234_5678;
    mstHSEL        = 3'b011;
    mstpriority[0] = 3'd0;
    tick(1);
    chk("t4_grant_m1", 64'(master_granted), 64'h2);
    chk("t4_hwdata_m0", 64'(slv_HWDATA), 64'hDEAD_BEEF);
    tick(1);
    chk("t4_hwdata_m1", 64'(slv_HWDATA), 64'h1234_5678);

    // Equal-priority contention after a fresh reset.
    HRESETn = 1'b0;
    #1 chk("t5_reset", 64'(master_granted), 64'h1);
    tick(1);
    HRESETn = 1'b1;
    mstHSEL = 3'b111;
    for (int i = 0; i < M; i++) mstpriority[i] = 3'd3;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("t5_tie_grant", 64'(master_granted), 64'(1) << exp_rr[k]);
    end

    // Wait states freeze grant and data owner; reset mid-wait.
    mstHSEL        = 3'b010;
    mstpriority[1] = 3'd0;
    tick(2);
    chk("t6_grant_m1", 64'(master_granted), 64'h2);
    mstHWDATA[0]   = 32'h0BAD_F00D;
    mstHWDATA[1]   = 32'hCAFE_0001;
    slv_HREADY     = 1'b0;
    mstHSEL        = 3'b011;
    mstpriority[0] = 3'd7;
    for (int w = 0; w < 2; w++) begin
      tick(1);
      chk("t6_wait_grant", 64'(master_granted), 64'h2);
      chk("t6_wait_hwdata", 64'(slv_HWDATA), 64'hCAFE_0001);
    end
    #2 HRESETn = 1'b0;
    #1 chk("t6_async_reset", 64'(master_granted), 64'h1);
    chk("t6_reset_hwdata", 64'(slv_HWDATA), 64'h0BAD_F00D);
    tick(1);
    HRESETn    = 1'b1;
    slv_HREADY = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      mstHSEL      = M'($urandom);
      mstHWRITE    = M'($urandom);
      mstHMASTLOCK = M'($urandom);
      mstHREADY    = M'($urandom);
      can_switch   = M'($urandom_range(0, 3) != 0 ? 7 : $urandom);
      for (int i = 0; i < M; i++) begin
        mstpriority[i] = 3'($urandom_range(0, 3) == 0 ? $urandom : 3);
        mstHADDR[i]    = $urandom;
        mstHWDATA[i]   = $urandom;
        mstHSIZE[i]    = 3'($urandom);
        mstHBURST[i]   = 3'($urandom);
        mstHPROT[i]    = 4'($urandom);
        mstHTRANS[i]   = 2'($urandom);
      end
      slv_HRDATA = $urandom;
      slv_HREADY = ($urandom_range(0, 3) != 0);
      slv_HRESP  = 1'($urandom);
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
